// File: rtl/mul_seq.sv
// Sequential unsigned shift-add multiplier: one adder step per cycle, WIDTH steps,
// 2*WIDTH-bit product and a one-cycle done pulse.

module adder #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow
);

  logic [WIDTH:0] full;

  always_comb begin
    full       = {1'b0, in_x} + {1'b0, in_y};
    out_result = full[WIDTH-1:0];
    out_carry  = full[WIDTH];
    if (SIGNED != 0)
      out_overflow = (in_x[WIDTH-1] == in_y[WIDTH-1]) && (full[WIDTH-1] != in_x[WIDTH-1]);
    else
      out_overflow = full[WIDTH];
  end

endmodule

module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic               in_start,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplier,
  output logic               out_busy,
  output logic               out_done,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_y;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_carry;
  logic                 add_ovf_unused;

  assign add_y = acc_lo_q[0] ? mcand_q : '0;

  adder #(
    .WIDTH  (WIDTH),
    .SIGNED (0)
  ) u_adder (
    .in_x         (acc_hi_q),
    .in_y         (add_y),
    .out_result   (add_sum),
    .out_carry    (add_carry),
    .out_overflow (add_ovf_unused)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_start) begin
          mcand_d  = in_multiplicand;
          acc_hi_d = '0;
          acc_lo_d = in_multiplier;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // {carry, sum, acc_lo} >> 1, low 2*WIDTH bits kept
        acc_hi_d = {add_carry, add_sum[WIDTH-1:1]};
        acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Product is captured on the DONE-entry edge so it is valid with out_done
          product_d = {acc_hi_d, acc_lo_d};
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign out_busy    = (state_q != IDLE);
  assign out_done    = (state_q == DONE);
  assign out_product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: WIDTH=8 and WIDTH=32 instances, hand-computed results.

module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [63:0] prod32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(8)) dut8 (
    .in_clk          (clk),
    .in_rst_n        (rst_n),
    .in_start        (start8),
    .in_multiplicand (a8),
    .in_multiplier   (b8),
    .out_busy        (busy8),
    .out_done        (done8),
    .out_product     (prod8)
  );

  mul_seq #(.WIDTH(32)) dut32 (
    .in_clk          (clk),
    .in_rst_n        (rst_n),
    .in_start        (start32),
    .in_multiplicand (a32),
    .in_multiplier   (b32),
    .out_busy        (busy32),
    .out_done        (done32),
    .out_product     (prod32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start accepted at edge 0; done expected after edge 8, busy after edges 0..8.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int done_at, busy_cnt, done_cnt;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    busy_cnt = busy8 ? 1 : 0;
    done_at  = -1;
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          chk({tag, "_prod"}, 64'(prod8), 64'(exp));
        end
      end
    end
    chk({tag, "_done_edge"}, 64'(done_at), 64'd8);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd9);
    chk({tag, "_prod_hold"}, 64'(prod8), 64'(exp));
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    int done_at, busy_cnt, done_cnt;
    @(posedge clk); #1;
    start32 = 1'b1; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0; a32 = '0; b32 = '0;
    busy_cnt = busy32 ? 1 : 0;
    done_at  = -1;
    done_cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      if (busy32) busy_cnt++;
      if (done32) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          chk({tag, "_prod"}, prod32, exp);
        end
      end
    end
    chk({tag, "_done_edge"}, 64'(done_at), 64'd32);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
  endtask

  initial begin
    int done_cnt;
    int done_edges[$];
    logic unstable;
    logic [15:0] exp_p;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_prod8", 64'(prod8), 64'd0);
    chk("rst_prod32", prod32, 64'd0);
    rst_n = 1'b1;

    run8("m3x5", 8'd3, 8'd5, 16'h000F);
    run8("m255x255", 8'd255, 8'd255, 16'hFE01);

    run32("w32_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run32("w32_zero", 32'h0, 32'h1234_5678, 64'h0);

    // Second start during CALC must be ignored
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
    @(posedge clk); #1;
    start8 = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin start8 = 1'b1; a8 = 8'd2; b8 = 8'd2; end
      if (k == 4) start8 = 1'b0;
      if (done8) done_cnt++;
    end
    chk("ignore_done_cnt", 64'(done_cnt), 64'd1);
    chk("ignore_prod", 64'(prod8), 64'h003F);

    // Asynchronous reset mid-CALC aborts without a done pulse
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_prod", 64'(prod8), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (done8) done_cnt++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) done_cnt++;
    end
    chk("abort_no_done", 64'(done_cnt), 64'd0);

    run8("m6x7", 8'd6, 8'd7, 16'h002A);

    // Start held high: back-to-back every WIDTH+2 cycles
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd10;
    unstable = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done8) done_edges.push_back(k);
      exp_p = (done_edges.size() > 0) ? 16'h0064 : 16'h002A;
      if (prod8 !== exp_p) unstable = 1'b1;
    end
    start8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("b2b_done_cnt", 64'(done_edges.size()), 64'd3);
    if (done_edges.size() >= 3) begin
      chk("b2b_first", 64'(done_edges[0]), 64'd8);
      chk("b2b_gap1", 64'(done_edges[1] - done_edges[0]), 64'd10);
      chk("b2b_gap2", 64'(done_edges[2] - done_edges[1]), 64'd10);
    end
    chk("b2b_prod_stable", 64'(unstable), 64'd0);
    chk("b2b_prod", 64'(prod8), 64'h0064);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
